subleq_mem_arbiter: RTL and testbench
=====================================

// Module: subleq_mem_arbiter
// PURPOSE
//  Shares one single-port subleq memory between N_REQ requesters (subleq cores, program loader, debug port).
//  Round-robin arbitration, one access accepted per cycle, fixed 2-cycle read latency back to the requester.
//  Optional bus locking gives a core an atomic read-p/read-q/read-d/write sequence.
//  Sits between the core memory ports and the memory array.
// PARAMETERS
//  N_REQ    2   number of requesters (>=1)
//  ADDR_W   8   memory address width
//  DATA_W   8   memory word width
//  LOCK_MAX 16  max cycles a lock may be held before forced release (>=1)
// PORTS
//  clock          in   1             single clock, all logic on posedge
//  reset_n        in   1             synchronous, active-low reset
//  req_i          in   N_REQ         per-requester access request
//  we_i           in   N_REQ         1=write, 0=read (qualified by req_i)
//  lock_i         in   N_REQ         hold bus after this access (used only with SUBLEQ_ARB_LOCK_EN)
//  addr_i         in   N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//  wdata_i        in   N_REQ*DATA_W  packed write data, same packing
//  gnt_o          out  N_REQ         combinational accept; req_i[i]&gnt_o[i] = access accepted this cycle
//  rvalid_o       out  N_REQ         read data valid pulse for requester i
//  rdata_o        out  DATA_W        read data, shared, meaningful only with some rvalid_o bit set
//  mem_en_o       out  1             memory command valid (registered)
//  mem_we_o       out  1             memory write enable (registered)
//  mem_addr_o     out  ADDR_W        memory address (registered)
//  mem_wdata_o    out  DATA_W        memory write data (registered)
//  mem_rdata_i    in   DATA_W        memory read data, valid cycle after mem_en_o&!mem_we_o
//  lock_timeout_o out  1             one-cycle pulse on forced lock release
// BEHAVIOUR
//  Reset: all outputs 0, round-robin pointer ptr=0, state IDLE, lock counter 0, pending read pipeline flushed.
//  Arbitration (IDLE): at most one gnt_o bit set; winner = first requester with req_i high scanning ptr, ptr+1, ... mod N_REQ.
//  Acceptance in cycle t by i: ptr<=(i+1)%N_REQ; mem_* driven with i's addr/we/wdata in t+1, mem_en_o=1 for exactly that cycle.
//  Reads: rvalid_o[i]=1 and rdata_o=mem_rdata_i in t+2. Writes: no rvalid. Back-to-back acceptances every cycle allowed.
//  No request: gnt_o=0, mem_en_o=0 next cycle. N_REQ=1: gnt_o=req_i.
//  States IDLE, LOCKED(owner). IDLE->LOCKED on accepted access with lock_i=1 (macro on only).
//  LOCKED: only owner can be granted; counter cleared on entry, increments every LOCKED cycle (idle cycles included).
//  LOCKED->IDLE on accepted owner access with lock_i=0 (that access issues normally), ptr<=owner+1.
//  LOCKED->IDLE when counter reaches LOCK_MAX: lock_timeout_o=1 one cycle, ptr<=owner+1, no grant that cycle.
//  Owner unlock acceptance in same cycle as timeout: acceptance wins, no timeout pulse.
//  Owner access with lock_i=1 in LOCKED: stays LOCKED, counter NOT cleared.
//  Reset asserted mid-operation: in-flight read dropped (no rvalid), lock released, no timeout pulse.
//  Address/data pass through unmodified; no wrap or arithmetic on addresses.
// CONFIGURATION
//  SUBLEQ_ARB_LOCK_EN defined: LOCKED state, counter, lock_timeout_o active as above.
//  Not defined: lock_i ignored, FSM never leaves IDLE, lock_timeout_o tied 0, no counter logic.
// STRUCTURE
//  subleq_pkg: ADDR_W/DATA_W defaults, arb_state_t enum {IDLE, LOCKED}.
//  Sub-module subleq_rr_picker: combinational (req vector, ptr) -> one-hot grant + index.
//  Top holds FSM, ptr, lock counter, command register, 2-stage read-return tag pipeline.
// TESTING
//  Reset: reset_n=0 3 cycles, req_i all 1 -> gnt_o=0, mem_en_o=0, rvalid_o=0, lock_timeout_o=0.
//  Read: req0 read addr 0x10, mem[0x10]=0x5A -> gnt_o=01 at t, mem_addr_o=0x10 t+1, rvalid_o=01 rdata_o=0x5A t+2.
//  Contention: req0,req1 held 4 cycles after reset -> accepts 0,1,0,1; mem_en_o high 4 consecutive cycles.
//  Write: req1 write 0x20<-0xFE -> mem_we_o=1 t+1, no rvalid; later req0 read 0x20 -> rdata_o=0xFE.
//  Lock (macro on): req0 lock reads 0x00,0x01,0x02, write lock=0; req1 held -> gnt_o[1]=0 until write accepted, then 1.
//  Timeout (macro on, LOCK_MAX=4): req0 locked read then req0 idle, req1 held -> lock_timeout_o pulse 4 cycles later, next cycle gnt_o=10.

Source files
------------

// File: rtl/subleq_pkg.sv
// Shared definitions for the subleq memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default memory address / word widths
//   arb_state_t             : arbiter FSM state (IDLE, LOCKED)
package subleq_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    IDLE,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/subleq_rr_picker.sv
// Combinational round-robin picker.
//   req_i   : per-requester request vector
//   ptr_i   : highest-priority requester this cycle
//   gnt_o   : one-hot grant (all zero when nothing requests)
//   idx_o   : index of the granted requester
//   valid_o : some requester was picked
module subleq_rr_picker #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    logic [PTR_W-1:0] j;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = '0;
    // Scan ptr, ptr+1, ... wrapping at N_REQ; the first requester found wins.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      j = PTR_W'((32'(ptr_i) + k) % N_REQ);
      if (!valid_o && req_i[j]) begin
        gnt_o[j] = 1'b1;
        idx_o    = j;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/subleq_mem_arbiter.sv
// Round-robin arbiter sharing one single-port subleq memory between N_REQ requesters.
// One access is accepted per cycle; the command is registered onto mem_* the next cycle and
// read data returns to the requester two cycles after acceptance.
// Optional bus locking is compiled in with the macro SUBLEQ_ARB_LOCK_EN.
// Ports:
//   clock, reset_n          : clock, synchronous active-low reset
//   req_i/we_i/lock_i       : per-requester request, write enable, hold-bus-after-access
//   addr_i/wdata_i          : packed per-requester address and write data
//   gnt_o                   : combinational accept (req_i & gnt_o = accepted)
//   rvalid_o/rdata_o        : read return pulse per requester, shared read data
//   mem_en/we/addr/wdata_o  : registered memory command
//   mem_rdata_i             : memory read data, valid the cycle after a read command
//   lock_timeout_o          : pulse on forced lock release
module subleq_mem_arbiter
  import subleq_pkg::*;
#(
  parameter int unsigned N_REQ    = 2,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ-1:0]        we_i,
  input  logic [N_REQ-1:0]        lock_i,
  input  logic [N_REQ*ADDR_W-1:0] addr_i,
  input  logic [N_REQ*DATA_W-1:0] wdata_i,
  output logic [N_REQ-1:0]        gnt_o,
  output logic [N_REQ-1:0]        rvalid_o,
  output logic [DATA_W-1:0]       rdata_o,
  output logic                    mem_en_o,
  output logic                    mem_we_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [DATA_W-1:0]       mem_wdata_o,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  output logic                    lock_timeout_o
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  pick_gnt;
  logic [PTR_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [PTR_W-1:0]  ptr_q;
  logic              ptr_upd;
  logic              win;
  logic [PTR_W-1:0]  win_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  subleq_rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

`ifdef SUBLEQ_ARB_LOCK_EN
  localparam int unsigned CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  arb_state_t       state_q;
  logic [PTR_W-1:0] owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cnt_last;

  // Counter starts at 0 on entry, so LOCK_MAX-1 marks the final cycle the lock may be held.
  assign cnt_last = (state_q == LOCKED) && (cnt_q == CNT_W'(LOCK_MAX - 1));

  always_comb begin
    gnt_o          = '0;
    win            = 1'b0;
    win_idx        = pick_idx;
    lock_timeout_o = 1'b0;
    if (reset_n) begin
      if (state_q == IDLE) begin
        gnt_o = pick_gnt;
        win   = pick_valid;
      end else begin
        win_idx = owner_q;
        // On the final locked cycle only an unlocking owner access may still win.
        if (req_i[owner_q] && !(cnt_last && lock_i[owner_q])) begin
          gnt_o[owner_q] = 1'b1;
          win            = 1'b1;
        end
        lock_timeout_o = cnt_last && !win;
      end
    end
  end

  // On timeout win_idx already holds the owner, so the pointer moves past it.
  assign ptr_upd = win | lock_timeout_o;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win && lock_i[win_idx]) begin
            state_q <= LOCKED;
            owner_q <= win_idx;
            cnt_q   <= '0;
          end
        end
        LOCKED: begin
          if ((win && !lock_i[owner_q]) || lock_timeout_o) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end
`else
  logic unused_lock;

  assign unused_lock    = ^lock_i;
  assign gnt_o          = reset_n ? pick_gnt : '0;
  assign win            = reset_n & pick_valid;
  assign win_idx        = pick_idx;
  assign lock_timeout_o = 1'b0;
  assign ptr_upd        = win;
`endif

  // Select the winner's command fields.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_idx == PTR_W'(i)) begin
        sel_we    = we_i[i];
        sel_addr  = addr_i[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (ptr_upd) begin
      ptr_q <= (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd_pend_q;
  logic [PTR_W-1:0]  rd_idx_q;
  logic [N_REQ-1:0]  rvalid_q;
  logic [N_REQ-1:0]  rvalid_d;

  always_comb begin
    rvalid_d = '0;
    if (rd_pend_q) rvalid_d[rd_idx_q] = 1'b1;
  end

  // Command register plus two-stage tag pipeline matching the memory's one-cycle read latency.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      rd_idx_q    <= '0;
      rvalid_q    <= '0;
    end else begin
      mem_en_q <= win;
      mem_we_q <= win & sel_we;
      if (win) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      rd_pend_q <= win & ~sel_we;
      rd_idx_q  <= win_idx;
      rvalid_q  <= rvalid_d;
    end
  end

  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = (|rvalid_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_subleq_mem_arbiter.sv
// Self-checking bench for subleq_mem_arbiter (N_REQ=2, 8-bit address/data, LOCK_MAX=4).
// Lock scenarios are exercised when SUBLEQ_ARB_LOCK_EN is defined; otherwise lock_i is
// checked to have no effect.
module tb_subleq_mem_arbiter;

  logic        clock;
  logic        reset_n;
  logic [1:0]  req_i, we_i, lock_i;
  logic [15:0] addr_i, wdata_i;
  logic [1:0]  gnt_o, rvalid_o;
  logic [7:0]  rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [7:0]  mem_addr_o, mem_wdata_o, mem_rdata;
  logic        lock_timeout_o;

  logic [7:0] mem [256];
  int n_vec = 0;
  int n_err = 0;

  subleq_mem_arbiter #(
    .N_REQ    (2),
    .ADDR_W   (8),
    .DATA_W   (8),
    .LOCK_MAX (4)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req_i          (req_i),
    .we_i           (we_i),
    .lock_i         (lock_i),
    .addr_i         (addr_i),
    .wdata_i        (wdata_i),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .mem_en_o       (mem_en_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata),
    .lock_timeout_o (lock_timeout_o)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Single-port memory with one-cycle read latency.
  always @(posedge clock) begin
    if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o] <= mem_wdata_o;
      else          mem_rdata <= mem[mem_addr_o];
    end
  end

  typedef struct {
    logic [1:0] req, we, lock;
    logic [7:0] a0, a1, w0, w1;
    logic [1:0] gnt;
    logic       en, mwe;
    logic [7:0] maddr;
    logic [1:0] rv;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs after the falling edge and settle just before the rising edge.
  task automatic apply(input logic rn, input logic [1:0] req, input logic [1:0] we,
                       input logic [1:0] lock, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [7:0] w0, input logic [7:0] w1);
    @(negedge clock);
    reset_n = rn;
    req_i   = req;
    we_i    = we;
    lock_i  = lock;
    addr_i  = {a1, a0};
    wdata_i = {w1, w0};
    #3;
  endtask

  task automatic do_reset();
    apply(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    apply(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  logic [1:0] cg [7];
  logic       ce [7];
  logic [7:0] ca [7];
  logic [1:0] cr [7];
  logic [7:0] cd [7];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h10] = 8'h5A;
    mem_rdata  = 8'h00;
    reset_n = 1'b0; req_i = '0; we_i = '0; lock_i = '0; addr_i = '0; wdata_i = '0;

    // Reset held 3 cycles with every requester asking.
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 8'h00, 8'h00);
      chk("rst_gnt", gnt_o, 2'b00);
      chk("rst_mem_en", mem_en_o, 1'b0);
      chk("rst_rvalid", rvalid_o, 2'b00);
      chk("rst_timeout", lock_timeout_o, 1'b0);
    end

    //          req    we     lock   a0     a1     w0     w1     gnt    en    mwe   maddr  rv     rd
    tbl[0]  = '{2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00};
    tbl[1]  = '{2'b00, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'h10, 2'b00, 8'h00};
    tbl[2]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 8'h5A};
    tbl[3]  = '{2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00};
    tbl[4]  = '{2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b01, 1'b1, 1'b0, 8'h02, 2'b00, 8'h00};
    tbl[5]  = '{2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b10, 1'b1, 1'b0, 8'h01, 2'b10, 8'hA7};
    tbl[6]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'h02, 2'b01, 8'hA4};
    tbl[7]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b10, 8'hA7};
    tbl[8]  = '{2'b10, 2'b10, 2'b00, 8'h00, 8'h20, 8'h00, 8'hFE, 2'b10, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00};
    tbl[9]  = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 8'h20, 2'b00, 8'h00};
    tbl[10] = '{2'b01, 2'b00, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00, 2'b01, 1'b0, 1'b0, 8'h00, 2'b00, 8'h00};
    tbl[11] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'h20, 2'b00, 8'h00};
    tbl[12] = '{2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 1'b0, 8'h00, 2'b01, 8'hFE};

    for (int i = 0; i < 13; i++) begin
      apply(1'b1, tbl[i].req, tbl[i].we, tbl[i].lock, tbl[i].a0, tbl[i].a1, tbl[i].w0,
            tbl[i].w1);
      chk($sformatf("tbl%0d_gnt", i), gnt_o, tbl[i].gnt);
      chk($sformatf("tbl%0d_mem_en", i), mem_en_o, tbl[i].en);
      if (tbl[i].en) begin
        chk($sformatf("tbl%0d_mem_we", i), mem_we_o, tbl[i].mwe);
        chk($sformatf("tbl%0d_mem_addr", i), mem_addr_o, tbl[i].maddr);
      end
      if (tbl[i].en && tbl[i].mwe) chk($sformatf("tbl%0d_mem_wdata", i), mem_wdata_o, 8'hFE);
      chk($sformatf("tbl%0d_rvalid", i), rvalid_o, tbl[i].rv);
      if (tbl[i].rv != 2'b00) chk($sformatf("tbl%0d_rdata", i), rdata_o, tbl[i].rd);
      chk($sformatf("tbl%0d_timeout", i), lock_timeout_o, 1'b0);
    end

    // Contention straight after reset: accepts 0,1,0,1 and four back-to-back commands.
    cg = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    ce = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    ca = '{8'h00, 8'h30, 8'h31, 8'h30, 8'h31, 8'h00, 8'h00};
    cr = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    cd = '{8'h00, 8'h00, 8'h95, 8'h94, 8'h95, 8'h94, 8'h00};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      apply(1'b1, (c < 4) ? 2'b11 : 2'b00, 2'b00, 2'b00, 8'h30, 8'h31, 8'h00, 8'h00);
      chk($sformatf("cont%0d_gnt", c), gnt_o, cg[c]);
      chk($sformatf("cont%0d_mem_en", c), mem_en_o, ce[c]);
      if (ce[c]) chk($sformatf("cont%0d_mem_addr", c), mem_addr_o, ca[c]);
      chk($sformatf("cont%0d_rvalid", c), rvalid_o, cr[c]);
      if (cr[c] != 2'b00) chk($sformatf("cont%0d_rdata", c), rdata_o, cd[c]);
    end

    // Reset in the middle of a read drops the return.
    apply(1'b1, 2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00);
    chk("midrst_gnt", gnt_o, 2'b01);
    apply(1'b0, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    apply(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("midrst_rvalid_a", rvalid_o, 2'b00);
    chk("midrst_mem_en", mem_en_o, 1'b0);
    apply(1'b1, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("midrst_rvalid_b", rvalid_o, 2'b00);

`ifdef SUBLEQ_ARB_LOCK_EN
    // Locked read-p/read-q/read-d/write; requester 1 shut out until the unlocking write.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply(1'b1, 2'b11, 2'b00, 2'b01, 8'(c), 8'h40, 8'h00, 8'h00);
      chk($sformatf("lock%0d_gnt", c), gnt_o, 2'b01);
      chk($sformatf("lock%0d_timeout", c), lock_timeout_o, 1'b0);
    end
    apply(1'b1, 2'b11, 2'b01, 2'b00, 8'h03, 8'h40, 8'h77, 8'h00);
    chk("lock_wr_gnt", gnt_o, 2'b01);
    apply(1'b1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h40, 8'h00, 8'h00);
    chk("lock_after_gnt", gnt_o, 2'b10);
    chk("lock_after_mem_we", mem_we_o, 1'b1);

    // Lock abandoned by requester 0: forced release after LOCK_MAX cycles.
    do_reset();
    apply(1'b1, 2'b01, 2'b00, 2'b01, 8'h05, 8'h00, 8'h00, 8'h00);
    chk("tmo_lock_gnt", gnt_o, 2'b01);
    for (int c = 1; c < 4; c++) begin
      apply(1'b1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h41, 8'h00, 8'h00);
      chk($sformatf("tmo%0d_gnt", c), gnt_o, 2'b00);
      chk($sformatf("tmo%0d_timeout", c), lock_timeout_o, 1'b0);
    end
    apply(1'b1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h41, 8'h00, 8'h00);
    chk("tmo_pulse", lock_timeout_o, 1'b1);
    chk("tmo_pulse_gnt", gnt_o, 2'b00);
    apply(1'b1, 2'b10, 2'b00, 2'b00, 8'h00, 8'h41, 8'h00, 8'h00);
    chk("tmo_after_gnt", gnt_o, 2'b10);
    chk("tmo_after_timeout", lock_timeout_o, 1'b0);
`else
    // Without locking, lock_i has no effect on arbitration.
    do_reset();
    apply(1'b1, 2'b01, 2'b00, 2'b01, 8'h05, 8'h00, 8'h00, 8'h00);
    chk("nolock_gnt0", gnt_o, 2'b01);
    apply(1'b1, 2'b11, 2'b00, 2'b11, 8'h05, 8'h06, 8'h00, 8'h00);
    chk("nolock_gnt1", gnt_o, 2'b10);
    for (int c = 0; c < 5; c++) begin
      apply(1'b1, 2'b00, 2'b00, 2'b11, 8'h00, 8'h00, 8'h00, 8'h00);
      chk($sformatf("nolock%0d_timeout", c), lock_timeout_o, 1'b0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
